uart_rx_oversampled: RTL and testbench

Parametrised successor to the lab UART receiver. Recovers asynchronous serial frames from `serial_in` using 16x (parametrised) oversampling with a 3-sample majority vote. Supports configurable data width, parity and stop bits, flags framing, parity and overrun errors, and buffers received words in an internal FIFO. The FIFO drains through a ready/valid port. The block sits between the board's serial pin and the on-chip consumer, for example the echo or memory-controller datapath.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_rx_oversampled.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver.
//   PARITY_*    : parity mode encodings for the PARITY parameter
//   rx_state_e  : receiver FSM states
//   tick_div()  : oversample tick divider, rounded to nearest integer
//   maj3()      : 3-input majority vote
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // ST_ prefix keeps the state names clear of the PARITY parameter.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic int tick_div(input longint clock_freq, input longint baud,
                                  input longint os);
    return int'((clock_freq + (baud * os) / 2) / (baud * os));
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with an occupancy count.
//   clk, rst_n  : clock, synchronous active-low reset
//   wr_en_i     : push request (dropped when full unless a pop coincides)
//   wr_data_i   : push data
//   rd_en_i     : pop request (ignored when empty)
//   rd_data_o   : head word, valid while empty_o = 0
//   full_o      : count = DEPTH
//   empty_o     : count = 0
//   count_o     : current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign do_rd     = rd_en_i & ~empty_o;
  // A pop frees the slot at the same edge, so a full FIFO still accepts a push.
  assign do_wr     = wr_en_i & (~full_o | do_rd);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver with majority-vote bit recovery, optional parity,
// 1 or 2 stop bits, sticky error flags and a FWFT receive FIFO.
//   clk, rst_n      : clock, synchronous active-low reset
//   serial_in       : asynchronous serial line, idles high
//   data_out        : FIFO head word, LSB = first received bit
//   data_out_valid  : FIFO not empty
//   data_out_ready  : consumer accepts the head word
//   fifo_count      : FIFO occupancy
//   frame_error     : sticky, a stop bit was sampled low
//   parity_error    : sticky, parity check failed
//   overrun         : sticky, good frame arrived with the FIFO full
//   error_clear     : pulse, clears the sticky flags (a coincident set wins)
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          serial_in,
  output logic [DATA_BITS-1:0]          data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_error,
  output logic                          parity_error,
  output logic                          overrun,
  input  logic                          error_clear
);

  localparam int TICK_DIV = tick_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int M        = OVERSAMPLE / 2;

  // ---------------------------------------------------------------- sync
  logic [1:0] sync_q;
  logic       rx_s, rx_prev_q;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], serial_in};
      rx_prev_q <= rx_s;
    end
  end

  // ---------------------------------------------------------------- ticks
  rx_state_e      state_q;
  logic [TW-1:0]  tick_cnt_q;
  logic           tick, start_det;

  assign tick      = (tick_cnt_q == TW'(TICK_DIV - 1));
  // Edge-based: a line held low never looks like a new start bit.
  assign start_det = (state_q == ST_IDLE) & rx_prev_q & ~rx_s;

  // Free-running, realigned to the falling edge of each start bit.
  always_ff @(posedge clk) begin
    if (!rst_n || start_det || tick) tick_cnt_q <= '0;
    else                             tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  // ---------------------------------------------------------------- FSM
  logic [SW-1:0]        samp_q;
  logic [3:0]           bit_q;
  logic [1:0]           vote_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bad_q, stop_bad_q;
  logic                 done_q, set_fe_q, set_pe_q;
  logic                 mid, last_samp, vbit, stop_bad_now;

  // The vote resolves on the tick of the third sample, using the live rx_s.
  assign mid          = tick & (samp_q == SW'(M + 1));
  assign last_samp    = (samp_q == SW'(OVERSAMPLE - 1));
  assign vbit         = maj3(vote_q[0], vote_q[1], rx_s);
  assign stop_bad_now = stop_bad_q | ~vbit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      samp_q     <= '0;
      bit_q      <= '0;
      vote_q     <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      done_q     <= 1'b0;
      set_fe_q   <= 1'b0;
      set_pe_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      set_fe_q <= 1'b0;
      set_pe_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (start_det) begin
          state_q    <= ST_START;
          samp_q     <= '0;
          bit_q      <= '0;
          par_bad_q  <= 1'b0;
          stop_bad_q <= 1'b0;
        end
      end else if (tick) begin
        samp_q <= last_samp ? '0 : samp_q + SW'(1);
        if (samp_q == SW'(M - 1)) vote_q[0] <= rx_s;
        if (samp_q == SW'(M))     vote_q[1] <= rx_s;
        case (state_q)
          ST_START: begin
            if (mid && vbit)    state_q <= ST_IDLE;   // false start
            else if (last_samp) state_q <= ST_DATA;
          end
          ST_DATA: begin
            if (mid) shift_q <= {vbit, shift_q[DATA_BITS-1:1]};
            if (last_samp) begin
              if (bit_q == 4'(DATA_BITS - 1)) begin
                bit_q   <= '0;
                state_q <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                bit_q <= bit_q + 4'd1;
              end
            end
          end
          ST_PARITY: begin
            if (mid) par_bad_q <= ((^shift_q) ^ vbit) != (PARITY == PARITY_ODD);
            if (last_samp) state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (mid) begin
              stop_bad_q <= stop_bad_now;
              // Leave at the last stop mid-sample so the next start edge is caught.
              if (bit_q == 4'(STOP_BITS - 1)) begin
                state_q  <= ST_IDLE;
                set_fe_q <= stop_bad_now;
                set_pe_q <= ~stop_bad_now & par_bad_q;
                done_q   <= ~stop_bad_now & ~par_bad_q;
              end
            end else if (last_samp) begin
              bit_q <= bit_q + 4'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic fifo_full, fifo_empty, pop;

  assign pop            = data_out_ready & ~fifo_empty;
  assign data_out_valid = ~fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (done_q),
    .wr_data_i (shift_q),
    .rd_en_i   (data_out_ready),
    .rd_data_o (data_out),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // ---------------------------------------------------------------- flags
  logic fe_q, pe_q, ov_q;
  logic fe_d, pe_d, ov_d;

  assign fe_d = set_fe_q | (fe_q & ~error_clear);
  assign pe_d = set_pe_q | (pe_q & ~error_clear);
  assign ov_d = (done_q & fifo_full & ~pop) | (ov_q & ~error_clear);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fe_q <= 1'b0;
      pe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      fe_q <= fe_d;
      pe_q <= pe_d;
      ov_q <= ov_d;
    end
  end

  assign frame_error  = fe_q;
  assign parity_error = pe_q;
  assign overrun      = ov_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench: three receiver instances (8N1 default, 7E1, 8N1 with a
// 4-deep FIFO) scaled to 4 clocks per oversample tick, 64 clocks per bit.
module tb_uart_rx_oversampled;

  localparam int CF   = 32_000_000;
  localparam int BR   = 500_000;
  localparam int BITN = 640;          // nominal bit time in delay units
  localparam int BITF = 627;          // +2% baud
  localparam int BITS = 653;          // -2% baud

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic ser_a = 1'b1, ser_b = 1'b1, ser_c = 1'b1;
  logic rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;
  logic clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;

  logic [7:0] da;  logic va; logic [3:0] ca; logic fea, pea, ova;
  logic [6:0] db;  logic vb; logic [3:0] cb; logic feb, peb, ovb;
  logic [7:0] dc;  logic vc; logic [2:0] cc; logic fec, pec, ovc;

  uart_rx_oversampled #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) u_a (
    .clk(clk), .rst_n(rst_n), .serial_in(ser_a), .data_out(da), .data_out_valid(va),
    .data_out_ready(rdy_a), .fifo_count(ca), .frame_error(fea), .parity_error(pea),
    .overrun(ova), .error_clear(clr_a));

  uart_rx_oversampled #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(2)) u_b (
    .clk(clk), .rst_n(rst_n), .serial_in(ser_b), .data_out(db), .data_out_valid(vb),
    .data_out_ready(rdy_b), .fifo_count(cb), .frame_error(feb), .parity_error(peb),
    .overrun(ovb), .error_clear(clr_b));

  uart_rx_oversampled #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .serial_in(ser_c), .data_out(dc), .data_out_valid(vc),
    .data_out_ready(rdy_c), .fifo_count(cc), .frame_error(fec), .parity_error(pec),
    .overrun(ovc), .error_clear(clr_c));

  int tests = 0;
  int fails = 0;

  // Pop loggers; viol_a counts cycles where valid stayed up after a single-entry pop.
  logic [7:0] qa[$];
  logic [6:0] qb[$];
  logic [7:0] qc[$];
  int  viol_a = 0;
  bit  chk_a  = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_a && va) viol_a++;
      chk_a = 0;
      if (va && rdy_a) begin
        qa.push_back(da);
        if (ca == 4'd1) chk_a = 1;
      end
      if (vb && rdy_b) qb.push_back(db);
      if (vc && rdy_c) qc.push_back(dc);
    end
  end

  task automatic drive(input int ln, input logic v);
    case (ln)
      0: ser_a = v;
      1: ser_b = v;
      default: ser_c = v;
    endcase
  endtask

  // pbit < 0 means no parity bit.
  task automatic send(input int ln, input logic [8:0] d, input int nb, input int pbit,
                      input logic stopv, input int bt);
    drive(ln, 1'b0); #(bt);
    for (int i = 0; i < nb; i++) begin drive(ln, d[i]); #(bt); end
    if (pbit >= 0) begin drive(ln, pbit[0]); #(bt); end
    drive(ln, stopv); #(bt);
    drive(ln, 1'b1);
  endtask

  task automatic test_reset;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    tests++; if (va !== 1'b0)  begin fails++; $display("FAIL reset_valid: got %b expected 0", va); end
    tests++; if (ca !== 4'd0)  begin fails++; $display("FAIL reset_count: got %0d expected 0", ca); end
    tests++; if (da !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", da); end
    tests++; if ({fea, pea, ova} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {fea, pea, ova}); end
    tests++; if (vb !== 1'b0 || cb !== 4'd0) begin fails++; $display("FAIL reset_b: got v=%b c=%0d expected v=0 c=0", vb, cb); end
    tests++; if (vc !== 1'b0 || cc !== 3'd0) begin fails++; $display("FAIL reset_c: got v=%b c=%0d expected v=0 c=0", vc, cc); end
    tests++; if ({feb, peb, ovb, fec, pec, ovc} !== 6'b0) begin fails++; $display("FAIL reset_flags_bc: got %b expected 000000", {feb, peb, ovb, fec, pec, ovc}); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    qa.delete(); viol_a = 0; rdy_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e = 8'h61 + 8'(i);
      send(0, {1'b0, e}, 8, -1, 1'b1, BITN);
    end
    #(2 * BITN);
    tests++; if (qa.size() != 10) begin fails++; $display("FAIL b2b_count: got %0d expected 10", qa.size()); end
    for (int i = 0; i < 10; i++) begin
      e = 8'h61 + 8'(i);
      tests++;
      if (i >= qa.size() || qa[i] !== e) begin
        fails++; $display("FAIL b2b_word%0d: got %h expected %h", i, (i < qa.size()) ? qa[i] : 8'hxx, e);
      end
    end
    tests++; if (viol_a != 0) begin fails++; $display("FAIL b2b_valid_drop: got %0d late-valid cycles expected 0", viol_a); end
    tests++; if ({fea, pea, ova} !== 3'b000) begin fails++; $display("FAIL b2b_flags: got %b expected 000", {fea, pea, ova}); end
  endtask

  task automatic test_parity;
    qb.delete(); rdy_b = 1'b1;
    // 7'h41 has two ones, so even parity bit is 0.
    send(1, 9'h041, 7, 0, 1'b1, BITN);
    #(BITN);
    tests++; if (qb.size() != 1 || qb[0] !== 7'h41) begin fails++; $display("FAIL par_good: got n=%0d w=%h expected n=1 w=41", qb.size(), (qb.size() > 0) ? qb[0] : 7'h0); end
    tests++; if (peb !== 1'b0) begin fails++; $display("FAIL par_good_flag: got %b expected 0", peb); end
    send(1, 9'h041, 7, 1, 1'b1, BITN);
    #(BITN);
    tests++; if (qb.size() != 1) begin fails++; $display("FAIL par_bad_push: got n=%0d expected 1", qb.size()); end
    tests++; if (peb !== 1'b1) begin fails++; $display("FAIL par_bad_flag: got %b expected 1", peb); end
    tests++; if (feb !== 1'b0) begin fails++; $display("FAIL par_bad_fe: got %b expected 0", feb); end
    @(posedge clk); #1 clr_b = 1'b1;
    @(posedge clk); #1 clr_b = 1'b0;
    @(negedge clk);
    tests++; if (peb !== 1'b0) begin fails++; $display("FAIL par_clear: got %b expected 0", peb); end
  endtask

  task automatic test_frame_error;
    qa.delete(); rdy_a = 1'b1;
    send(0, 9'h055, 8, -1, 1'b0, BITN);
    #(2 * BITN);
    send(0, 9'h0AA, 8, -1, 1'b1, BITN);
    #(BITN);
    tests++; if (qa.size() != 1 || qa[0] !== 8'hAA) begin fails++; $display("FAIL fe_recover: got n=%0d w=%h expected n=1 w=aa", qa.size(), (qa.size() > 0) ? qa[0] : 8'h0); end
    tests++; if (fea !== 1'b1) begin fails++; $display("FAIL fe_flag: got %b expected 1", fea); end
    tests++; if (pea !== 1'b0) begin fails++; $display("FAIL fe_pe: got %b expected 0", pea); end
    @(posedge clk); #1 clr_a = 1'b1;
    @(posedge clk); #1 clr_a = 1'b0;
    @(negedge clk);
    tests++; if (fea !== 1'b0) begin fails++; $display("FAIL fe_clear: got %b expected 0", fea); end
  endtask

  task automatic test_glitch;
    qa.delete(); rdy_a = 1'b1;
    ser_a = 1'b0; #200; ser_a = 1'b1;   // under half a bit
    #(12 * BITN);
    tests++; if (qa.size() != 0) begin fails++; $display("FAIL glitch_push: got n=%0d expected 0", qa.size()); end
    tests++; if ({fea, pea, ova} !== 3'b000) begin fails++; $display("FAIL glitch_flags: got %b expected 000", {fea, pea, ova}); end
    // Receiver must still be able to take a real frame afterwards.
    send(0, 9'h03C, 8, -1, 1'b1, BITN);
    #(BITN);
    tests++; if (qa.size() != 1 || qa[0] !== 8'h3C) begin fails++; $display("FAIL glitch_after: got n=%0d w=%h expected n=1 w=3c", qa.size(), (qa.size() > 0) ? qa[0] : 8'h0); end
  endtask

  task automatic test_overrun;
    logic [7:0] e;
    qc.delete(); rdy_c = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = 8'h31 + 8'(i);
      send(2, {1'b0, e}, 8, -1, 1'b1, BITN);
    end
    #(BITN);
    tests++; if (cc !== 3'd4) begin fails++; $display("FAIL ovr_count: got %0d expected 4", cc); end
    tests++; if (ovc !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b expected 1", ovc); end
    tests++; if (vc !== 1'b1 || dc !== 8'h31) begin fails++; $display("FAIL ovr_head: got v=%b w=%h expected v=1 w=31", vc, dc); end
    @(posedge clk); #1 rdy_c = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    tests++; if (qc.size() != 4) begin fails++; $display("FAIL ovr_drain_n: got %0d expected 4", qc.size()); end
    for (int i = 0; i < 4; i++) begin
      e = 8'h31 + 8'(i);
      tests++;
      if (i >= qc.size() || qc[i] !== e) begin
        fails++; $display("FAIL ovr_word%0d: got %h expected %h", i, (i < qc.size()) ? qc[i] : 8'hxx, e);
      end
    end
    tests++; if (cc !== 3'd0 || vc !== 1'b0) begin fails++; $display("FAIL ovr_empty: got c=%0d v=%b expected c=0 v=0", cc, vc); end
  endtask

  task automatic test_baud_skew;
    logic [7:0] pat [16];
    pat = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h80, 8'h3C, 8'hC3,
            8'h7E, 8'h81, 8'h0F, 8'hF0, 8'h55, 8'hAA, 8'h12, 8'hED};
    qa.delete(); rdy_a = 1'b1;
    for (int i = 0; i < 16; i++) send(0, {1'b0, pat[i]}, 8, -1, 1'b1, (i < 8) ? BITF : BITS);
    #(2 * BITN);
    tests++; if (qa.size() != 16) begin fails++; $display("FAIL skew_count: got %0d expected 16", qa.size()); end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (i >= qa.size() || qa[i] !== pat[i]) begin
        fails++; $display("FAIL skew_word%0d: got %h expected %h", i, (i < qa.size()) ? qa[i] : 8'hxx, pat[i]);
      end
    end
    tests++; if ({fea, pea, ova} !== 3'b000) begin fails++; $display("FAIL skew_flags: got %b expected 000", {fea, pea, ova}); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_parity();
    test_frame_error();
    test_glitch();
    test_overrun();
    test_baud_skew();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
